peridot_board_gpio: RTL and testbench

//  Parametrised board-support core for PERIDOT-class boards, instantiated beneath the board top
//  (CLOCK_50 domain). Provides a GPIO bank of GPIO_WIDTH pins, and per-pin output enables. Pads are

---
 rtl/peridot_board_pkg.sv | 29 ++
 rtl/peridot_sync_edge.sv | 36 +++
 rtl/peridot_board_gpio.sv | 166 ++++++++++++++++
 tb/tb_peridot_board_gpio.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peridot_board_pkg.sv
// Shared definitions for the PERIDOT board-support core: register map, LED modes
// and the ready-sequencer state type.
package peridot_board_pkg;

    localparam logic [2:0] REG_DOUT = 3'd0;
    localparam logic [2:0] REG_OE   = 3'd1;
    localparam logic [2:0] REG_DIN  = 3'd2;
    localparam logic [2:0] REG_EDGE = 3'd3;
    localparam logic [2:0] REG_MASK = 3'd4;
    localparam logic [2:0] REG_LED  = 3'd5;
    localparam logic [2:0] REG_STAT = 3'd6;
    localparam logic [2:0] REG_RSVD = 3'd7;

    localparam logic [1:0] LED_OFF   = 2'd0;
    localparam logic [1:0] LED_ON    = 2'd1;
    localparam logic [1:0] LED_BLINK = 2'd2;
    localparam logic [1:0] LED_IRQ   = 2'd3;

    typedef enum logic {
        SEQ_WAIT  = 1'b0,
        SEQ_READY = 1'b1
    } seq_state_t;

    // STAT word: bit0 = ready, bits[13:8] = bank width
    function automatic logic [31:0] stat_word(input logic ready, input int width);
        stat_word = {18'd0, 6'(width), 7'd0, ready};
    endfunction

endpackage

// File: rtl/peridot_sync_edge.sv
// Multi-bit input synchroniser with a one-cycle rising-edge pulse on the synced value.
// Shared by PERIDOT peripherals that sample asynchronous pads.
module peridot_sync_edge #(
    parameter int WIDTH       = 30,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] sync_p [SYNC_STAGES];
    logic [WIDTH-1:0] sync_last_p;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_p[i] <= '0;
            end
            sync_last_p <= '0;
        end else begin
            sync_p[0] <= async_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_p[i] <= sync_p[i-1];
            end
            sync_last_p <= sync_p[SYNC_STAGES-1];
        end
    end

    assign sync_out = sync_p[SYNC_STAGES-1];
    // Pulse is valid for the cycle in which the synced value first reads 1
    assign rise     = sync_out & ~sync_last_p;

endmodule

// File: rtl/peridot_board_gpio.sv
// PERIDOT board-support core: GPIO bank with output enables, edge-capture IRQ,
// status LED and post-reset ready sequencer behind a 32-bit Avalon-MM slave.
module peridot_board_gpio
    import peridot_board_pkg::*;
#(
    parameter int GPIO_WIDTH    = 30,
    parameter int SYNC_STAGES   = 2,
    parameter int LED_DIV_WIDTH = 24,
    parameter int READY_DELAY   = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            avs_address,
    input  logic                  avs_read,
    output logic [31:0]           avs_readdata,
    input  logic                  avs_write,
    input  logic [31:0]           avs_writedata,
    output logic                  ins_irq,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    output logic                  led,
    output logic                  sys_ready
);

    localparam int RDY_W = (READY_DELAY > 1) ? $clog2(READY_DELAY) : 1;
    localparam logic [RDY_W-1:0] RDY_LAST = RDY_W'(READY_DELAY - 1);

    logic [GPIO_WIDTH-1:0]    dout_q;
    logic [GPIO_WIDTH-1:0]    oe_q;
    logic [GPIO_WIDTH-1:0]    edge_q;
    logic [GPIO_WIDTH-1:0]    mask_q;
    logic [1:0]               led_mode_q;
    logic [LED_DIV_WIDTH-1:0] presc_q;
    logic                     led_q;
    logic                     irq_q;
    logic [31:0]              readdata_q;
    logic [31:0]              rd_mux;

    seq_state_t               seq_state;
    logic [RDY_W-1:0]         rdy_cnt_q;
    logic                     ready_q;

    logic [GPIO_WIDTH-1:0]    din;
    logic [GPIO_WIDTH-1:0]    din_rise;
    logic [GPIO_WIDTH-1:0]    wdata_bank;
    logic [GPIO_WIDTH-1:0]    edge_clr;
    logic                     irq_next;
    logic                     presc_wrap;
    logic                     unused_wdata;

    function automatic logic [31:0] bank_word(input logic [GPIO_WIDTH-1:0] v);
        bank_word = 32'(v);
    endfunction

    peridot_sync_edge #(
        .WIDTH       (GPIO_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .reset    (reset),
        .async_in (gpio_in),
        .sync_out (din),
        .rise     (din_rise)
    );

    assign wdata_bank   = avs_writedata[GPIO_WIDTH-1:0];
    assign unused_wdata = ^avs_writedata;
    assign edge_clr     = (avs_write && avs_address == REG_EDGE) ? wdata_bank : '0;
    assign irq_next     = |(edge_q & mask_q);
    assign presc_wrap   = &presc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q     <= '0;
            oe_q       <= '0;
            mask_q     <= '0;
            led_mode_q <= LED_OFF;
        end else if (avs_write) begin
            case (avs_address)
                REG_DOUT: dout_q     <= wdata_bank;
                REG_OE:   oe_q       <= wdata_bank;
                REG_MASK: mask_q     <= wdata_bank;
                REG_LED:  led_mode_q <= avs_writedata[1:0];
                default:  ;
            endcase
        end
    end

    // A new edge in the same cycle as its w1c wins, so the set is applied after the clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            edge_q <= (edge_q & ~edge_clr) | din_rise;
            irq_q  <= irq_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            led_q   <= 1'b0;
        end else begin
            presc_q <= presc_q + 1'b1;
            case (led_mode_q)
                LED_OFF:   led_q <= 1'b0;
                LED_ON:    led_q <= 1'b1;
                LED_BLINK: if (presc_wrap) led_q <= ~led_q;
                LED_IRQ:   led_q <= irq_next;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_state <= SEQ_WAIT;
            rdy_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (seq_state)
                SEQ_WAIT: begin
                    if (rdy_cnt_q == RDY_LAST) begin
                        seq_state <= SEQ_READY;
                        ready_q   <= 1'b1;
                    end else begin
                        rdy_cnt_q <= rdy_cnt_q + 1'b1;
                    end
                end
                SEQ_READY: ready_q <= 1'b1;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            REG_DOUT: rd_mux = bank_word(dout_q);
            REG_OE:   rd_mux = bank_word(oe_q);
            REG_DIN:  rd_mux = bank_word(din);
            REG_EDGE: rd_mux = bank_word(edge_q);
            REG_MASK: rd_mux = bank_word(mask_q);
            REG_LED:  rd_mux = {30'd0, led_mode_q};
            REG_STAT: rd_mux = stat_word(ready_q, GPIO_WIDTH);
            default:  rd_mux = '0;
        endcase
    end

    // Read data is captured only on a read strobe and held otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_q <= '0;
        end else if (avs_read) begin
            readdata_q <= rd_mux;
        end
    end

    assign avs_readdata = readdata_q;
    assign gpio_out     = dout_q;
    assign gpio_oe      = oe_q;
    assign ins_irq      = irq_q;
    assign led          = led_q;
    assign sys_ready    = ready_q;

endmodule

// File: tb/tb_peridot_board_gpio.sv
// Self-checking bench for peridot_board_gpio: directed table, multi-cycle corner
// sequences and randomized traffic against a behavioural model.
module tb_peridot_board_gpio;
    import peridot_board_pkg::*;

    localparam int GW  = 30;
    localparam int SS  = 2;
    localparam int LDW = 4;
    localparam int RD  = 16;
    localparam logic [31:0] WMASK = (32'd1 << GW) - 32'd1;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    avs_address;
    logic          avs_read;
    logic [31:0]   avs_readdata;
    logic          avs_write;
    logic [31:0]   avs_writedata;
    logic          ins_irq;
    logic [GW-1:0] gpio_in;
    logic [GW-1:0] gpio_out;
    logic [GW-1:0] gpio_oe;
    logic          led;
    logic          sys_ready;

    always #5 clk = ~clk;

    peridot_board_gpio #(
        .GPIO_WIDTH    (GW),
        .SYNC_STAGES   (SS),
        .LED_DIV_WIDTH (LDW),
        .READY_DELAY   (RD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .ins_irq       (ins_irq),
        .gpio_in       (gpio_in),
        .gpio_out      (gpio_out),
        .gpio_oe       (gpio_oe),
        .led           (led),
        .sys_ready     (sys_ready)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    logic [31:0] m_dout, m_oe, m_edge, m_mask, m_rd;
    logic [1:0]  m_mode;
    logic        m_led, m_irq, m_ready;
    int          m_cnt, m_cycles;
    logic [31:0] hist [SS+1];   // hist[0] = pad value sampled at the latest edge
    logic [GW-1:0] gin_cur;

    typedef struct {
        logic [2:0]  addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_out;
        logic [31:0] exp_oe;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t tbl [15];

    task automatic model_reset();
        m_dout = 0; m_oe = 0; m_edge = 0; m_mask = 0; m_rd = 0;
        m_mode = 0; m_led = 0; m_irq = 0; m_ready = 0;
        m_cnt = 0; m_cycles = 0;
        for (int i = 0; i <= SS; i++) hist[i] = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            REG_DOUT: return m_dout;
            REG_OE:   return m_oe;
            REG_DIN:  return hist[SS-1];
            REG_EDGE: return m_edge;
            REG_MASK: return m_mask;
            REG_LED:  return 32'(m_mode);
            REG_STAT: return (32'(GW) << 8) | 32'(m_ready);
            default:  return 32'd0;
        endcase
    endfunction

    task automatic model_edge(input logic [2:0] a, input logic r, input logic w,
                              input logic [31:0] d, input logic [GW-1:0] g);
        logic [31:0] rise, nedge;
        logic nirq, nled;
        rise = hist[SS-1] & ~hist[SS];
        if (r) m_rd = m_read(a);
        nirq = (m_edge & m_mask) != 0;
        case (m_mode)
            2'd0: nled = 1'b0;
            2'd1: nled = 1'b1;
            2'd2: nled = (m_cnt == (1 << LDW) - 1) ? ~m_led : m_led;
            default: nled = nirq;
        endcase
        nedge = m_edge;
        if (w && a == REG_EDGE) nedge = nedge & ~d;
        nedge = (nedge | rise) & WMASK;
        if (w) begin
            case (a)
                REG_DOUT: m_dout = d & WMASK;
                REG_OE:   m_oe   = d & WMASK;
                REG_MASK: m_mask = d & WMASK;
                REG_LED:  m_mode = d[1:0];
                default:  ;
            endcase
        end
        m_edge = nedge;
        m_irq  = nirq;
        m_led  = nled;
        m_cnt  = (m_cnt + 1) % (1 << LDW);
        for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = 32'(g);
        m_cycles++;
        m_ready = (m_cycles >= RD);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        vectors++;
        if (gpio_out !== m_dout[GW-1:0] || gpio_oe !== m_oe[GW-1:0] || ins_irq !== m_irq ||
            led !== m_led || sys_ready !== m_ready || avs_readdata !== m_rd) begin
            miscompares++;
            $display("FAIL model_%s at %0t: out=%h/%h oe=%h/%h irq=%b/%b led=%b/%b rdy=%b/%b rd=%h/%h (got/expected)",
                     tag, $time, gpio_out, m_dout[GW-1:0], gpio_oe, m_oe[GW-1:0], ins_irq, m_irq,
                     led, m_led, sys_ready, m_ready, avs_readdata, m_rd);
        end
    endtask

    // Called at posedge+1: drive one bus cycle, clock it, then compare with the model
    task automatic step(input logic [2:0] a, input logic r, input logic w,
                        input logic [31:0] d, input logic [GW-1:0] g);
        avs_address = a; avs_read = r; avs_write = w; avs_writedata = d; gpio_in = g;
        @(posedge clk);
        model_edge(a, r, w, d, g);
        #1;
        avs_read = 1'b0; avs_write = 1'b0;
        check_model("step");
    endtask

    task automatic idle();
        step(REG_DOUT, 1'b0, 1'b0, 32'd0, gin_cur);
    endtask

    task automatic ready_wait();
        for (int i = 1; i <= RD + 1; i++) begin
            idle();
            check("ready_seq", 32'(sys_ready), (i >= RD) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic async_reset();
        #3 reset = 1'b1;
        #1;
        model_reset();
        check("rst_gpio_out", 32'(gpio_out), 32'd0);
        check("rst_gpio_oe", 32'(gpio_oe), 32'd0);
        check("rst_flags", {29'd0, ins_irq, led, sys_ready}, 32'd0);
        check("rst_readdata", avs_readdata, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int ntog, last_t;
        int tog_t [8];
        logic last_led;

        reset = 1'b1;
        avs_address = 0; avs_read = 0; avs_write = 0; avs_writedata = 0;
        gin_cur = '0; gpio_in = '0;
        model_reset();

        tbl[0]  = '{REG_DOUT, 1'b0, 1'b1, 32'h2AAAAAAA, 32'h2AAAAAAA, 32'h0,      32'h00001E01};
        tbl[1]  = '{REG_OE,   1'b0, 1'b1, 32'h0000FFFF, 32'h2AAAAAAA, 32'h0000FFFF, 32'h00001E01};
        tbl[2]  = '{REG_DOUT, 1'b1, 1'b0, 32'h0,        32'h2AAAAAAA, 32'h0000FFFF, 32'h2AAAAAAA};
        tbl[3]  = '{REG_OE,   1'b1, 1'b0, 32'h0,        32'h2AAAAAAA, 32'h0000FFFF, 32'h0000FFFF};
        tbl[4]  = '{REG_DIN,  1'b0, 1'b1, 32'hFFFFFFFF, 32'h2AAAAAAA, 32'h0000FFFF, 32'h0000FFFF};
        tbl[5]  = '{REG_DIN,  1'b1, 1'b0, 32'h0,        32'h2AAAAAAA, 32'h0000FFFF, 32'h0};
        tbl[6]  = '{REG_OE,   1'b1, 1'b0, 32'h0,        32'h2AAAAAAA, 32'h0000FFFF, 32'h0000FFFF};
        tbl[7]  = '{REG_RSVD, 1'b0, 1'b1, 32'h12345678, 32'h2AAAAAAA, 32'h0000FFFF, 32'h0000FFFF};
        tbl[8]  = '{REG_RSVD, 1'b1, 1'b0, 32'h0,        32'h2AAAAAAA, 32'h0000FFFF, 32'h0};
        tbl[9]  = '{REG_MASK, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h2AAAAAAA, 32'h0000FFFF, 32'h0};
        tbl[10] = '{REG_MASK, 1'b1, 1'b0, 32'h0,        32'h2AAAAAAA, 32'h0000FFFF, 32'h3FFFFFFF};
        tbl[11] = '{REG_DOUT, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h3FFFFFFF, 32'h0000FFFF, 32'h3FFFFFFF};
        tbl[12] = '{REG_DOUT, 1'b1, 1'b0, 32'h0,        32'h3FFFFFFF, 32'h0000FFFF, 32'h3FFFFFFF};
        tbl[13] = '{REG_MASK, 1'b0, 1'b1, 32'h0,        32'h3FFFFFFF, 32'h0000FFFF, 32'h3FFFFFFF};
        tbl[14] = '{REG_DOUT, 1'b0, 1'b1, 32'h2AAAAAAA, 32'h2AAAAAAA, 32'h0000FFFF, 32'h3FFFFFFF};

        repeat (2) @(posedge clk);
        #1;
        check("reset_gpio_out", 32'(gpio_out), 32'd0);
        check("reset_gpio_oe", 32'(gpio_oe), 32'd0);
        check("reset_flags", {29'd0, ins_irq, led, sys_ready}, 32'd0);
        check("reset_readdata", avs_readdata, 32'd0);
        reset = 1'b0;

        // Ready sequencer and STAT
        ready_wait();
        step(REG_STAT, 1'b1, 1'b0, 32'd0, gin_cur);
        check("stat", avs_readdata, 32'h00001E01);

        // Register map table
        foreach (tbl[i]) begin
            step(tbl[i].addr, tbl[i].rd, tbl[i].wr, tbl[i].wdata, gin_cur);
            check("tbl_gpio_out", 32'(gpio_out), tbl[i].exp_out);
            check("tbl_gpio_oe", 32'(gpio_oe), tbl[i].exp_oe);
            check("tbl_readdata", avs_readdata, tbl[i].exp_rd);
        end

        // Rising edge on pin 5 with MASK=0x20
        step(REG_MASK, 1'b0, 1'b1, 32'h20, gin_cur);
        gin_cur = 30'h20;
        repeat (3) idle();
        check("irq_before", 32'(ins_irq), 32'd0);
        step(REG_EDGE, 1'b1, 1'b0, 32'd0, gin_cur);
        check("edge_read", avs_readdata, 32'h20);
        check("irq_after", 32'(ins_irq), 32'd1);

        // w1c in the same cycle as a new edge on the same pin
        gin_cur = '0;
        repeat (3) idle();
        gin_cur = 30'h20;
        repeat (2) idle();
        step(REG_EDGE, 1'b0, 1'b1, 32'h20, gin_cur);
        idle();
        check("w1c_race_irq", 32'(ins_irq), 32'd1);
        step(REG_EDGE, 1'b1, 1'b0, 32'd0, gin_cur);
        check("w1c_race_edge", avs_readdata, 32'h20);

        // Plain w1c clears the IRQ
        step(REG_EDGE, 1'b0, 1'b1, 32'h20, gin_cur);
        idle();
        check("w1c_clear_irq", 32'(ins_irq), 32'd0);

        // Blink mode: toggles every 2^LDW clocks
        step(REG_LED, 1'b0, 1'b1, 32'd2, gin_cur);
        ntog = 0;
        last_led = led;
        for (int t = 0; t < 64; t++) begin
            idle();
            if (led !== last_led && ntog < 8) begin
                tog_t[ntog] = t;
                ntog++;
            end
            last_led = led;
        end
        check("blink_toggles", 32'(ntog), 32'd4);
        last_t = tog_t[0];
        for (int k = 1; k < ntog && k < 8; k++) begin
            check("blink_period", 32'(tog_t[k] - last_t), 32'd16);
            last_t = tog_t[k];
        end

        // Mirror mode: led follows ins_irq
        step(REG_LED, 1'b0, 1'b1, 32'd3, gin_cur);
        gin_cur = '0;
        repeat (3) idle();
        gin_cur = 30'h20;
        for (int t = 0; t < 6; t++) begin
            idle();
            check("led_mirror", 32'(led), 32'(m_irq));
        end
        check("led_irq_on", 32'(led), 32'd1);
        step(REG_EDGE, 1'b0, 1'b1, 32'h20, gin_cur);
        repeat (2) idle();
        check("led_irq_off", 32'(led), 32'd0);

        // EDGE=0xFF with LED blinking, then asynchronous reset
        step(REG_EDGE, 1'b0, 1'b1, 32'hFFFFFFFF, gin_cur);
        gin_cur = '0;
        repeat (3) idle();
        gin_cur = 30'hFF;
        repeat (3) idle();
        step(REG_EDGE, 1'b1, 1'b0, 32'd0, gin_cur);
        check("edge_ff", avs_readdata, 32'hFF);
        step(REG_LED, 1'b0, 1'b1, 32'd2, gin_cur);
        repeat (5) idle();
        async_reset();
        ready_wait();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [2:0]  a;
            logic        r, w;
            logic [31:0] d;
            a = 3'($urandom_range(0, 7));
            r = 1'($urandom_range(0, 1));
            w = ($urandom_range(0, 2) == 0);
            d = $urandom;
            if ($urandom_range(0, 3) == 0)
                gin_cur = gin_cur ^ (30'd1 << $urandom_range(0, GW - 1));
            if (n == 300) async_reset();
            step(a, r, w, d, gin_cur);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
